div_iter_unit: RTL

Iterative radix-2 restoring divider. It is the inverse-direction counterpart of the shift-add multiplier cell in the M-extension datapath. It executes RV32M DIV/DIVU/REM/REMU one quotient bit per cycle, with a start/ready handshake toward the EX stage. It supports pipeline flush and RISC-V-defined results for divide-by-zero and signed overflow.

---
 rtl/div_iter_unit_if.sv | 23 ++
 rtl/div_iter_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/div_iter_unit_if.sv
// rtl/div_iter_unit_if.sv - EX-stage request/response bundle for the iterative divider.
interface div_iter_unit_if #(
  parameter int XLEN = 32
);
  logic            flush_i;
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            busy_o;
  logic            ready_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output flush_i, start_i, op_i, dividend_i, divisor_i,
    input  busy_o, ready_o, result_o
  );

  modport slave (
    input  flush_i, start_i, op_i, dividend_i, divisor_i,
    output busy_o, ready_o, result_o
  );
endinterface

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_FAST_SPECIAL_EN to let divide-by-zero and signed overflow skip the iteration phase.
module div_iter_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic             clk_i,
  input logic             rst_ni,
  div_iter_unit_if.slave  div_if
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

`ifdef DIV_FAST_SPECIAL_EN
  localparam bit FastSpecial = 1'b1;
`else
  localparam bit FastSpecial = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  IntMin   = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, dvd_orig_q, result_q;
  logic            is_rem_q, neg_q_q, neg_r_q, dz_q, ovf_q;

  logic            in_signed, dvd_neg, dvs_neg, in_dz, in_ovf, accept;
  logic [XLEN-1:0] dvd_mag, dvs_mag;
  logic [XLEN:0]   shifted, trial;
  logic            trial_ok;
  logic [XLEN-1:0] q_fin, r_fin;

  // Operand decode happens on the raw inputs so everything is captured in the accept cycle.
  assign in_signed = ~div_if.op_i[0];
  assign dvd_neg   = in_signed & div_if.dividend_i[XLEN-1];
  assign dvs_neg   = in_signed & div_if.divisor_i[XLEN-1];
  assign dvd_mag   = dvd_neg ? (~div_if.dividend_i + XLEN'(1)) : div_if.dividend_i;
  assign dvs_mag   = dvs_neg ? (~div_if.divisor_i + XLEN'(1)) : div_if.divisor_i;
  assign in_dz     = (div_if.divisor_i == '0);
  assign in_ovf    = in_signed & (div_if.dividend_i == IntMin) & (&div_if.divisor_i);
  assign accept    = (state_q == IDLE) & div_if.start_i & ~div_if.flush_i;

  assign shifted  = {rem_q, quo_q[XLEN-1]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign trial_ok = ~trial[XLEN];

  always_comb begin
    q_fin = neg_q_q ? (~quo_q + XLEN'(1)) : quo_q;
    r_fin = neg_r_q ? (~rem_q + XLEN'(1)) : rem_q;
    if (dz_q) begin
      q_fin = '1;
      r_fin = dvd_orig_q;
    end else if (ovf_q) begin
      q_fin = IntMin;
      r_fin = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (FastSpecial && (in_dz || in_ovf)) ? SIGN : CALC;
        end
      end
      CALC: begin
        if (cnt_q == LastIter) begin
          state_d = SIGN;
        end
      end
      SIGN:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (div_if.flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dvd_orig_q <= '0;
      result_q   <= '0;
      is_rem_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q      <= '0;
        rem_q      <= '0;
        quo_q      <= dvd_mag;
        dvs_q      <= dvs_mag;
        dvd_orig_q <= div_if.dividend_i;
        is_rem_q   <= div_if.op_i[1];
        neg_q_q    <= in_signed & (div_if.dividend_i[XLEN-1] ^ div_if.divisor_i[XLEN-1]) & ~in_dz;
        neg_r_q    <= dvd_neg;
        dz_q       <= in_dz;
        ovf_q      <= in_ovf;
      end else if ((state_q == CALC) && !div_if.flush_i) begin
        // The dividend magnitude sits in quo_q and is shifted out MSB-first as quotient bits enter.
        rem_q <= trial_ok ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], trial_ok};
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if ((state_q == SIGN) && !div_if.flush_i) begin
        result_q <= is_rem_q ? r_fin : q_fin;
      end
    end
  end

  assign div_if.busy_o   = (state_q == CALC) || (state_q == SIGN);
  assign div_if.ready_o  = (state_q == DONE);
  assign div_if.result_o = result_q;

endmodule
